sdram_arbiter: RTL and testbench

- Front end placed directly upstream of the 32 MHz SDRAM controller.
- Arbitrates two requesters (port A: chipset, high priority; port B: CPU/ROM loader) and a periodic refresh timer.
- Turns each grant into one fixed-length controller slot: a cs rising edge with addr/we/ds/din held stable for the whole slot.
- For reads, captures the controller's combinational dout at a fixed latency and returns it with a one-cycle ack.

---
 rtl/sdram_arbiter_pkg.sv | 11 +
 rtl/sdram_refresh_timer.sv | 32 +++
 rtl/sdram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the SDRAM front-end arbiter.
package sdram_arbiter_pkg;

    localparam int         ADDR_W  = 22;
    localparam logic [1:0] DS_NONE = 2'b11;

    typedef enum logic {IDLE, SLOT} state_t;

    typedef enum logic [1:0] {OWN_REF, OWN_A, OWN_B} owner_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 240
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic pend
);

    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] refresh_cnt;
    logic          wrap;

    assign wrap = (refresh_cnt == CW'(REFRESH_CYCLES - 1));

    // A wrap coinciding with a grant wins, so that refresh is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            pend        <= 1'b0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
            if (wrap)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates refresh, port A and port B into fixed-length SDRAM controller slots.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES    = 12,
    parameter int CS_HIGH_CYCLES = 6,
    parameter int READ_LATENCY   = 7,
    parameter int REFRESH_CYCLES = 240
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_ds,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [1:0]        a_ds,
    input  logic [15:0]       a_din,
    output logic              a_ack,
    output logic [15:0]       a_dout,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [1:0]        b_ds,
    input  logic [15:0]       b_din,
    output logic              b_ack,
    output logic [15:0]       b_dout
);

    localparam int SW = $clog2(SLOT_CYCLES);

    if (!(CS_HIGH_CYCLES < READ_LATENCY && READ_LATENCY < SLOT_CYCLES &&
          SLOT_CYCLES - CS_HIGH_CYCLES >= 3)) begin : g_bad_params
        $error("sdram_arbiter: inconsistent slot timing parameters");
    end

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [SW-1:0]     slot_cnt, slot_cnt_d, slot_nxt;
    logic              cs_d, we_d, refresh_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        ds_d;
    logic [15:0]       din_d, a_dout_d, b_dout_d;
    logic              a_ack_d, b_ack_d;
    logic              refresh_pend, refresh_clr;

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (refresh_clr),
        .pend   (refresh_pend)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        slot_cnt_d  = slot_cnt;
        cs_d        = mem_cs;
        we_d        = mem_we;
        refresh_d   = mem_refresh;
        addr_d      = mem_addr;
        ds_d        = mem_ds;
        din_d       = mem_din;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_dout_d    = a_dout;
        b_dout_d    = b_dout;
        refresh_clr = 1'b0;
        slot_nxt    = slot_cnt + SW'(1);

        case (state_q)
            IDLE: begin
                if (mem_ready && (refresh_pend || a_req || b_req)) begin
                    state_d    = SLOT;
                    slot_cnt_d = '0;
                    cs_d       = 1'b1;
                    refresh_d  = refresh_pend;
                    if (refresh_pend) begin
                        owner_d     = OWN_REF;
                        we_d        = 1'b0;
                        ds_d        = DS_NONE;
                        refresh_clr = 1'b1;
                    end else if (a_req) begin
                        owner_d = OWN_A;
                        we_d    = a_we;
                        addr_d  = a_addr;
                        ds_d    = a_ds;
                        din_d   = a_din;
                    end else begin
                        owner_d = OWN_B;
                        we_d    = b_we;
                        addr_d  = b_addr;
                        ds_d    = b_ds;
                        din_d   = b_din;
                    end
                end
            end
            SLOT: begin
                slot_cnt_d = slot_nxt;
                cs_d       = (slot_nxt < SW'(CS_HIGH_CYCLES));
                // Ack is registered so it is visible during the last slot cycle.
                if (slot_nxt == SW'(SLOT_CYCLES - 1)) begin
                    a_ack_d = (owner_q == OWN_A);
                    b_ack_d = (owner_q == OWN_B);
                end
                if (slot_cnt == SW'(READ_LATENCY) && !mem_we) begin
                    if (owner_q == OWN_A) a_dout_d = mem_dout;
                    if (owner_q == OWN_B) b_dout_d = mem_dout;
                end
                if (slot_cnt == SW'(SLOT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    slot_cnt_d = '0;
                    cs_d       = 1'b0;
                    refresh_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_REF;
            slot_cnt    <= '0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_ds      <= DS_NONE;
            mem_din     <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_dout      <= '0;
            b_dout      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            slot_cnt    <= slot_cnt_d;
            mem_cs      <= cs_d;
            mem_we      <= we_d;
            mem_refresh <= refresh_d;
            mem_addr    <= addr_d;
            mem_ds      <= ds_d;
            mem_din     <= din_d;
            a_ack       <= a_ack_d;
            b_ack       <= b_ack_d;
            a_dout      <= a_dout_d;
            b_dout      <= b_dout_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_ready = 1'b0;
    logic        mem_cs, mem_we, mem_refresh;
    logic [21:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = 16'h0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [21:0] a_addr = '0;
    logic [1:0]  a_ds = 2'b11;
    logic [15:0] a_din = '0;
    logic        a_ack;
    logic [15:0] a_dout;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [21:0] b_addr = '0;
    logic [1:0]  b_ds = 2'b11;
    logic [15:0] b_din = '0;
    logic        b_ack;
    logic [15:0] b_dout;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] exp_a_dout = '0;
    logic [15:0] exp_b_dout = '0;

    sdram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_din(a_din),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_din(b_din),
        .b_ack(b_ack), .b_dout(b_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        reset_n   = 1'b0;
        mem_ready = ready;
        a_req     = 1'b0;
        b_req     = 1'b0;
        mem_dout  = 16'h0;
        repeat (2) tick;
        reset_n    = 1'b1;
        exp_a_dout = '0;
        exp_b_dout = '0;
    endtask

    task automatic drive_a(input logic we, input logic [21:0] addr, input logic [1:0] ds,
                           input logic [15:0] din);
        a_we = we; a_addr = addr; a_ds = ds; a_din = din; a_req = 1'b1;
    endtask

    task automatic drive_b(input logic we, input logic [21:0] addr, input logic [1:0] ds,
                           input logic [15:0] din);
        b_we = we; b_addr = addr; b_ds = ds; b_din = din; b_req = 1'b1;
    endtask

    task automatic wait_cs(input int max, output int waited);
        waited = 0;
        while (mem_cs !== 1'b1 && waited < max) begin
            tick;
            waited++;
        end
    endtask

    // Entered at the negedge of slot cycle 0; leaves at the negedge of the following idle cycle.
    task automatic run_slot(input string tag, input owner_t own, input logic we,
                            input logic [21:0] addr, input logic [1:0] ds,
                            input logic [15:0] din, input logic [15:0] rd);
        for (int k = 0; k < 12; k++) begin
            if (k == 8 && !we && own == OWN_A) exp_a_dout = rd;
            if (k == 8 && !we && own == OWN_B) exp_b_dout = rd;
            check({tag, "/cs"}, mem_cs, 32'(k < 6));
            check({tag, "/refresh"}, mem_refresh, 32'(own == OWN_REF));
            check({tag, "/we"}, mem_we, (own == OWN_REF) ? 32'd0 : 32'(we));
            check({tag, "/ds"}, mem_ds, (own == OWN_REF) ? 32'd3 : 32'(ds));
            if (own != OWN_REF) begin
                check({tag, "/addr"}, mem_addr, 32'(addr));
                check({tag, "/din"}, mem_din, 32'(din));
            end
            check({tag, "/a_ack"}, a_ack, 32'(k == 11 && own == OWN_A));
            check({tag, "/b_ack"}, b_ack, 32'(k == 11 && own == OWN_B));
            check({tag, "/a_dout"}, a_dout, 32'(exp_a_dout));
            check({tag, "/b_dout"}, b_dout, 32'(exp_b_dout));
            mem_dout = (k == 7) ? rd : (16'h0F00 ^ 16'(k));
            if (k == 11 && own == OWN_A) a_req = 1'b0;
            if (k == 11 && own == OWN_B) b_req = 1'b0;
            tick;
        end
        check({tag, "/idle_cs"}, mem_cs, 32'd0);
        check({tag, "/idle_refresh"}, mem_refresh, 32'd0);
        check({tag, "/idle_acks"}, {a_ack, b_ack}, 32'd0);
    endtask

    initial begin
        int w;
        int seen;

        // Reset values
        #2 reset_n = 1'b0;
        tick;
        check("rst/cs_we_ref", {mem_cs, mem_we, mem_refresh}, 32'd0);
        check("rst/addr", mem_addr, 32'd0);
        check("rst/ds", mem_ds, 32'd3);
        check("rst/din", mem_din, 32'd0);
        check("rst/acks", {a_ack, b_ack}, 32'd0);
        check("rst/douts", {a_dout, b_dout}, 32'd0);

        // Port A read, then port B read and write
        do_reset(1'b1);
        drive_a(1'b0, 22'h012345, 2'b00, 16'h0000);
        wait_cs(600, w);
        check("a_rd/grant_latency", w, 32'd1);
        run_slot("a_rd", OWN_A, 1'b0, 22'h012345, 2'b00, 16'h0000, 16'hBEEF);
        drive_b(1'b0, 22'h000777, 2'b00, 16'h0000);
        wait_cs(600, w);
        check("b_rd/grant_latency", w, 32'd1);
        run_slot("b_rd", OWN_B, 1'b0, 22'h000777, 2'b00, 16'h0000, 16'h1234);
        drive_b(1'b1, 22'h3ABCDE, 2'b01, 16'hA55A);
        wait_cs(600, w);
        check("b_wr/grant_latency", w, 32'd1);
        run_slot("b_wr", OWN_B, 1'b1, 22'h3ABCDE, 2'b01, 16'hA55A, 16'h7777);

        // Simultaneous requests: A first, B one slot plus one idle cycle later
        do_reset(1'b1);
        drive_a(1'b0, 22'h001111, 2'b00, 16'h0000);
        drive_b(1'b0, 22'h002222, 2'b00, 16'h0000);
        wait_cs(600, w);
        check("prio/a_latency", w, 32'd1);
        run_slot("prio_a", OWN_A, 1'b0, 22'h001111, 2'b00, 16'h0000, 16'h1111);
        wait_cs(600, w);
        check("prio/b_after_idle", w, 32'd1);
        run_slot("prio_b", OWN_B, 1'b0, 22'h002222, 2'b00, 16'h0000, 16'h2222);

        // Idle refresh after 240 cycles
        do_reset(1'b1);
        wait_cs(600, w);
        check("ref/latency", w, 32'd241);
        run_slot("ref", OWN_REF, 1'b0, 22'h0, 2'b11, 16'h0, 16'h5555);

        // Refresh becomes due during a B slot while A waits: refresh goes before A
        do_reset(1'b1);
        repeat (230) tick;
        drive_b(1'b0, 22'h000042, 2'b10, 16'h0000);
        wait_cs(600, w);
        check("ref_a/b_latency", w, 32'd1);
        drive_a(1'b1, 22'h0000A0, 2'b00, 16'hC0DE);
        run_slot("ref_a_b", OWN_B, 1'b0, 22'h000042, 2'b10, 16'h0000, 16'h4242);
        wait_cs(600, w);
        check("ref_a/ref_latency", w, 32'd1);
        run_slot("ref_a_ref", OWN_REF, 1'b0, 22'h0, 2'b11, 16'h0, 16'h6666);
        wait_cs(600, w);
        check("ref_a/a_latency", w, 32'd1);
        run_slot("ref_a_a", OWN_A, 1'b1, 22'h0000A0, 2'b00, 16'hC0DE, 16'h9999);

        // mem_ready low blocks grants; refresh stays pending
        do_reset(1'b0);
        drive_a(1'b0, 22'h00BEEF, 2'b00, 16'h0000);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (mem_cs !== 1'b0 || a_ack !== 1'b0) seen++;
            tick;
        end
        check("notready/no_cs", seen, 32'd0);
        mem_ready = 1'b1;
        wait_cs(600, w);
        check("notready/ref_latency", w, 32'd1);
        run_slot("notready_ref", OWN_REF, 1'b0, 22'h0, 2'b11, 16'h0, 16'h3333);
        wait_cs(600, w);
        check("notready/a_latency", w, 32'd1);
        run_slot("notready_a", OWN_A, 1'b0, 22'h00BEEF, 2'b00, 16'h0000, 16'hCAFE);

        // Asynchronous reset in slot cycle 3
        do_reset(1'b1);
        drive_a(1'b0, 22'h00ABCD, 2'b00, 16'h0000);
        wait_cs(600, w);
        check("midrst/latency", w, 32'd1);
        repeat (3) tick;
        check("midrst/cs_before", mem_cs, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst/cs_async", mem_cs, 32'd0);
        check("midrst/addr_async", mem_addr, 32'd0);
        check("midrst/ds_async", mem_ds, 32'd3);
        tick;
        tick;
        check("midrst/no_ack", {a_ack, b_ack}, 32'd0);
        reset_n = 1'b1;
        wait_cs(600, w);
        check("midrst/regrant", w, 32'd1);
        run_slot("midrst_a", OWN_A, 1'b0, 22'h00ABCD, 2'b00, 16'h0000, 16'hD00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
